uart_tx_packetizer: RTL and testbench

- Upstream stage of the UART transmitter, in the 100 MHz clk domain.
- Buffers 16-bit acoustic samples in a synchronous FIFO and frames them into fixed-length packets: sync, sequence, samples, checksum.
- Presents one byte at a time on the transmitter's TX_en/TX_Data_in inputs.
- Paces bytes with the transmitter's slow, CDC-delayed TX_Ready using a full four-phase handshake.

---
 rtl/uart_pkt_pkg.sv | 21 ++
 rtl/uart_sample_fifo.sv | 49 ++++
 rtl/uart_tx_packetizer.sv | 138 +++++++++++++
 tb/tb_uart_tx_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants and types for the UART transmit packetizer: sync bytes,
// FSM state encoding and the byte-index width helper.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ASSERT,
        RELEASE,
        NEXT
    } state_t;

    // Bits needed to index every byte of a packet of pkt_len bytes.
    function automatic int unsigned byte_idx_w(input int unsigned pkt_len);
        return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
    endfunction

endpackage

// File: rtl/uart_sample_fifo.sv
// Synchronous sample FIFO with first-word-fall-through read data.
// Pushes while full and pops while empty are ignored.
module uart_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // NOTE: storage is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Buffers samples and frames them as AA 55 SEQ {MSB LSB}* CHK, handing each
// byte to the UART transmitter with a four-phase TX_en/TX_Ready handshake.
module uart_tx_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int PKT_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ready,
    input  logic                tx_ready,
    output logic                tx_en,
    output logic [7:0]          tx_data,
    output logic                overflow,
    output logic                busy
);

    localparam int PKT_LEN = 4 + 2 * PKT_SAMPLES;
    localparam int IW      = byte_idx_w(PKT_LEN);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
    localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_SAMPLES);

    state_t                state;
    logic [IW-1:0]         byte_idx;
    logic [7:0]            seq;
    logic [7:0]            chk;
    logic [SAMPLE_W-1:0]   hold;

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic [CW-1:0]         fifo_count;
    logic [SAMPLE_W-1:0]   fifo_rdata;

    logic [IW-1:0]         next_idx;
    logic [7:0]            chk_nxt;
    logic [7:0]            next_byte;
    logic                  next_is_msb;

    assign sample_ready = !full;
    assign pop          = (state == LOAD) && !empty;

    uart_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .wdata (sample_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Byte following the one just handshaken; sample MSBs come through LOAD instead.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        next_idx    = byte_idx + IW'(1);
        chk_nxt     = (byte_idx >= IW'(2)) ? (chk ^ tx_data) : chk;
        next_is_msb = next_idx[0] && (next_idx >= IW'(3)) && (next_idx < LAST_IDX);
        if (next_idx == IW'(1))       next_byte = SYNC1;
        else if (next_idx == IW'(2))  next_byte = seq;
        else if (next_idx == LAST_IDX) next_byte = chk_nxt;
        else                          next_byte = hold[7:0];
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            seq      <= '0;
            chk      <= '0;
            hold     <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (sample_valid && full) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if ((fifo_count >= PKT_CNT) && tx_ready) begin
                        byte_idx <= '0;
                        tx_data  <= SYNC0;
                        tx_en    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (!tx_ready) begin
                        tx_en <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (tx_ready) state <= NEXT;
                end
                NEXT: begin
                    if (byte_idx == LAST_IDX) begin
                        seq   <= seq + 8'd1;
                        chk   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        byte_idx <= next_idx;
                        chk      <= chk_nxt;
                        if (next_is_msb) begin
                            state <= LOAD;
                        end else begin
                            tx_data <= next_byte;
                            tx_en   <= 1'b1;
                            state   <= ASSERT;
                        end
                    end
                end
                LOAD: begin
                    hold    <= fifo_rdata;
                    tx_data <= fifo_rdata[SAMPLE_W-1 -: 8];
                    tx_en   <= 1'b1;
                    state   <= ASSERT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Self-checking bench: known-answer packet table, directed corner sequences and
// randomized traffic scored against a queue-based packet model.
module tb_uart_tx_packetizer;

    localparam int PKT     = 4;
    localparam int PKT_LEN = 4 + 2 * PKT;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_ready;
    logic        tx_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        overflow;
    logic        busy;

    logic        model_rdy = 1'b1;
    logic        stuck_low = 1'b0;
    assign tx_ready = model_rdy && !stuck_low;

    always #5 clk = ~clk;

    uart_tx_packetizer #(
        .SAMPLE_W    (16),
        .FIFO_DEPTH  (16),
        .PKT_SAMPLES (PKT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .tx_ready     (tx_ready),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .overflow     (overflow),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int stab_viol = 0;
    int rise_viol = 0;
    int abort_gen = 0;
    int rx_total = 0;
    int lo_min = 3, lo_max = 3, hi_min = 20, hi_max = 20;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] smp_q[$];
    logic [7:0]  ref_seq = 8'h00;

    typedef struct {
        logic [7:0]  seq;
        logic [15:0] smp [PKT];
        logic [7:0]  chk;
    } vec_t;
    vec_t tab [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packet model: whole packets are formed once enough samples are queued.
    task automatic build_packets();
        logic [7:0]  c;
        logic [15:0] s;
        while (smp_q.size() >= PKT) begin
            exp_q.push_back(8'hAA);
            exp_q.push_back(8'h55);
            exp_q.push_back(ref_seq);
            c = ref_seq;
            for (int k = 0; k < PKT; k++) begin
                s = smp_q.pop_front();
                exp_q.push_back(s[15:8]);
                exp_q.push_back(s[7:0]);
                c = c ^ s[15:8] ^ s[7:0];
            end
            exp_q.push_back(c);
            ref_seq = ref_seq + 8'd1;
        end
    endtask

    // Transmitter stand-in: latch a byte on tx_en, drop ready later, raise it after tx_en falls.
    logic [7:0] cap_b;
    int         cap_gen;
    int         wait_n;

    task automatic hold_chk();
        if (cap_gen == abort_gen && tx_data !== cap_b) stab_viol++;
    endtask

    always begin : xmtr_model
        @(negedge clk);
        if (tx_en === 1'b1 && tx_ready) begin
            cap_b   = tx_data;
            cap_gen = abort_gen;
            rx_q.push_back(cap_b);
            rx_total++;
            repeat ($urandom_range(lo_max, lo_min)) begin @(negedge clk); hold_chk(); end
            model_rdy = 1'b0;
            wait_n = 0;
            while (tx_en === 1'b1 && wait_n < 4000) begin @(negedge clk); hold_chk(); wait_n++; end
            check("tx_en drop after ready low", {31'd0, tx_en}, 0);
            repeat ($urandom_range(hi_max, hi_min)) begin @(negedge clk); hold_chk(); end
            model_rdy = 1'b1;
        end
    end

    logic en_s, rdy_s;
    always @(posedge clk) begin : rise_mon
        en_s  = tx_en;
        rdy_s = tx_ready;
        #1;
        if (tx_en === 1'b1 && en_s === 1'b0 && !rdy_s) rise_viol++;
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic push_raw(input logic [15:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        check("sample_ready on push", {31'd0, sample_ready}, 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic push_sample(input logic [15:0] d);
        push_raw(d);
        smp_q.push_back(d);
        build_packets();
    endtask

    task automatic wait_done(input int n, input int bound, input string what);
        int k = 0;
        while (!(rx_q.size() >= n && busy === 1'b0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({what, " within bound"}, {31'd0, k < bound}, 1);
    endtask

    task automatic drain();
        int idx = 0;
        wait_done(exp_q.size(), exp_q.size() * 300 + 2000, "drain");
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check($sformatf("stream byte %0d", idx), {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
            idx++;
        end
        check("unmatched bytes", rx_q.size() + exp_q.size(), 0);
        check("busy after drain", {31'd0, busy}, 0);
    endtask

    task automatic run_random(input int npkt);
        int base = rx_total;
        int pushed = 0;
        int k;
        logic stalled = 1'b0;
        for (int i = 0; i < npkt * PKT; i++) begin
            k = 0;
            while ((pushed - PKT * ((rx_total - base) / PKT_LEN)) >= 16 && k < 20000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20000) stalled = 1'b1;
            repeat ($urandom_range(2, 0)) @(negedge clk);
            push_sample(16'($urandom));
            pushed++;
        end
        check("fifo room wait", {31'd0, stalled}, 0);
        drain();
    endtask

    initial begin : main
        int k;
        int acc;
        int hi_cnt;
        logic [7:0] e;
        logic [31:0] got;

        // CHK covers SEQ and sample bytes only: 00^12^34^AB^CD^00^01^FF^FF = 41
        tab[0].seq = 8'h00; tab[0].smp = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF}; tab[0].chk = 8'h41;
        tab[1].seq = 8'h01; tab[1].smp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000}; tab[1].chk = 8'h01;
        tab[2].seq = 8'h02; tab[2].smp = '{16'h8001, 16'h7FFE, 16'h5AA5, 16'hC33C}; tab[2].chk = 8'h02;

        reset = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset tx_en", {31'd0, tx_en}, 0);
        check("reset tx_data", {24'd0, tx_data}, 0);
        check("reset overflow", {31'd0, overflow}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset sample_ready", {31'd0, sample_ready}, 1);

        // Known-answer packets with the 3/20 clk ready model.
        for (int v = 0; v < 3; v++) begin
            for (int s = 0; s < PKT; s++) push_raw(tab[v].smp[s]);
            wait_done(PKT_LEN, 4000, $sformatf("vec%0d packet", v));
            for (int j = 0; j < PKT_LEN; j++) begin
                if (j == 0)                e = 8'hAA;
                else if (j == 1)           e = 8'h55;
                else if (j == 2)           e = tab[v].seq;
                else if (j == PKT_LEN - 1) e = tab[v].chk;
                else if (((j - 3) % 2) == 0) e = tab[v].smp[(j - 3) / 2][15:8];
                else                       e = tab[v].smp[(j - 3) / 2][7:0];
                got = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'hDEAD;
                check($sformatf("vec%0d byte%0d", v, j), got, {24'd0, e});
            end
            check("vec busy after packet", {31'd0, busy}, 0);
        end
        ref_seq = 8'h03;

        // Three samples never start a packet; the fourth does within 2 clk.
        for (int s = 0; s < 3; s++) push_sample(16'($urandom));
        hi_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_en === 1'b1) hi_cnt++;
        end
        check("no start with 3 samples", hi_cnt, 0);
        push_sample(16'($urandom));
        k = 0;
        while (tx_en !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("start latency <= 2 clk", {31'd0, (k + 1) <= 2}, 1);
        check("busy during packet", {31'd0, busy}, 1);
        drain();

        // Stuck ready: exactly 16 samples accepted, overflow sticky until reset.
        stuck_low = 1'b1;
        @(negedge clk);
        acc = 0;
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_data = 16'($urandom);
            if (sample_ready) acc++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("accepted while full", acc, 16);
        check("sample_ready when full", {31'd0, sample_ready}, 0);
        check("overflow set", {31'd0, overflow}, 1);
        repeat (5) @(negedge clk);
        check("overflow sticky", {31'd0, overflow}, 1);
        check("no tx while ready stuck", {31'd0, tx_en}, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stuck_low = 1'b0;
        check("overflow cleared", {31'd0, overflow}, 0);
        check("sample_ready after reset", {31'd0, sample_ready}, 1);
        repeat (5) @(negedge clk);
        check("no bytes after overflow", rx_q.size(), 0);
        smp_q.delete();
        exp_q.delete();
        ref_seq = 8'h00;

        // Reset during the 6th byte aborts the packet; the next one restarts at SEQ 0.
        for (int s = 0; s < PKT; s++) push_sample(16'($urandom));
        k = 0;
        while (rx_q.size() < 6 && k < 4000) begin @(negedge clk); k++; end
        check("reached 6th byte", {31'd0, k < 4000}, 1);
        abort_gen++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort tx_en", {31'd0, tx_en}, 0);
        check("abort tx_data", {24'd0, tx_data}, 0);
        check("abort busy", {31'd0, busy}, 0);
        check("abort sample_ready", {31'd0, sample_ready}, 1);
        for (int j = 0; j < 6; j++) begin
            got = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'hDEAD;
            check($sformatf("partial byte%0d", j), got, {24'd0, exp_q.pop_front()});
        end
        rx_q.delete();
        exp_q.delete();
        smp_q.delete();
        ref_seq = 8'h00;
        repeat (30) @(negedge clk);
        for (int s = 0; s < PKT; s++) push_sample(16'($urandom));
        drain();

        // Random ready delays 1..40 clk, then 257 packets at full speed to wrap SEQ.
        lo_min = 1; lo_max = 40; hi_min = 1; hi_max = 40;
        run_random(4);
        lo_min = 1; lo_max = 1; hi_min = 1; hi_max = 1;
        run_random(257);

        check("tx_data stable during handshake", stab_viol, 0);
        check("tx_en rise with ready low", rise_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
